uart_send_drain: RTL and testbench

UART_SEND_DRAIN -- requirements
Module: uart_send_drain

---
 rtl/uart_send_drain.sv | 156 +++++++++++++++
 tb/tb_uart_send_drain.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_send_drain.sv
// Byte FIFO that drains continuously into an 8N1 UART transmitter, counting finished frames on LED.
// Define UART_SEND_DRAIN_PARITY_EN to add an even-parity bit between data and stop (11-bit frame).
module uart_send_drain #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 512
) (
  input  logic       CLK,
  input  logic       INITIALIZE_N,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  output logic       UART_TX,
  output logic       tx_busy,
  output logic [7:0] LED
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_SEND_DRAIN_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

`ifdef UART_SEND_DRAIN_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push, pop, bit_end, stop_end, next_active;

  assign push        = push_valid & push_ready;
  assign bit_end     = (cyc_cnt == CYC_LAST);
  assign stop_end    = (state == STOP) && bit_end;
  // A new frame is loaded either from idle or straight out of the stop bit, so there is no idle gap.
  assign pop         = (count != '0) && ((state == IDLE) || stop_end);
  assign next_active = pop || ((state != IDLE) && !stop_end);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (!push && pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (!INITIALIZE_N) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      push_ready <= 1'b1;
    end else begin
      count      <= count_nxt;
      push_ready <= (count_nxt != CNT_FULL);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (pop) shreg <= mem[rd_ptr];
  end

  always_ff @(posedge CLK) begin
    if (!INITIALIZE_N) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      UART_TX <= 1'b1;
      tx_busy <= 1'b0;
      LED     <= '0;
    end else begin
      tx_busy <= next_active || (count_nxt != '0);
      cyc_cnt <= ((state == IDLE) || bit_end) ? '0 : cyc_cnt + CYC_ONE;
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            UART_TX <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            UART_TX <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_SEND_DRAIN_PARITY_EN
              state   <= PARITY;
              UART_TX <= even_parity(shreg);
`else
              state   <= STOP;
              UART_TX <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shreg[bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_SEND_DRAIN_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            UART_TX <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            LED <= LED + 8'd1;
            if (pop) begin
              state   <= START;
              UART_TX <= 1'b0;
            end else begin
              state   <= IDLE;
              UART_TX <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          UART_TX <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_drain.sv
// Bench for uart_send_drain: queue-and-frame-timer reference model plus a mid-bit sampling receiver.
module tb_uart_send_drain;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_SEND_DRAIN_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       CLK = 1'b0;
  logic       INITIALIZE_N = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready, UART_TX, tx_busy;
  logic [7:0] LED;

  uart_send_drain #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .INITIALIZE_N(INITIALIZE_N), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .UART_TX(UART_TX), .tx_busy(tx_busy), .LED(LED)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: a byte queue, the frame in flight and its elapsed cycle count.
  logic [7:0] m_q[$];
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  int         m_frames = 0;
  logic       m_ready = 1'b1, m_tx = 1'b1, m_busy = 1'b0;
  logic [7:0] m_led = 8'h00;

  // Receiver decoding the serial line
  logic [7:0] rx_q[$];
  bit         rx_act = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_byte = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_SEND_DRAIN_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_update(input logic pv, input logic [7:0] pd, input logic rn);
    if (!rn) begin
      m_q.delete();
      m_act = 1'b0; m_t = 0; m_frames = 0; m_ready = 1'b1;
    end else begin
      if (m_act) begin
        if (m_t == FRAME_CYC - 1) begin
          m_frames++;
          m_act = 1'b0;
        end else m_t++;
      end
      if (!m_act && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_act = 1'b1;
        m_t = 0;
      end
      if (pv && m_ready) m_q.push_back(pd);
      m_ready = (m_q.size() != DEPTH);
    end
    m_tx   = m_act ? frame_bit(m_cur, m_t / CPB) : 1'b1;
    m_busy = m_act || (m_q.size() != 0);
    m_led  = 8'(m_frames);
  endtask

  task automatic tick(input logic pv, input logic [7:0] pd, input logic rn);
    push_valid = pv; push_data = pd; INITIALIZE_N = rn;
    @(posedge CLK);
    model_update(pv, pd, rn);
    #1;
    cyc++;
    if (!rn) rx_act = 1'b0;
    else if (!rx_act) begin
      if (UART_TX === 1'b0) begin rx_act = 1'b1; rx_n = 0; end
    end else begin
      rx_n++;
      if ((rx_n % CPB) == CPB / 2) begin
        if (rx_n / CPB >= 1 && rx_n / CPB <= 8) rx_byte[rx_n / CPB - 1] = UART_TX;
        if (rx_n / CPB == NBITS - 1) begin rx_q.push_back(rx_byte); rx_act = 1'b0; end
      end
    end
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    rx_q.delete();
  endtask

  task automatic test_reset();
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h55, 1'b0);
    vectors++;
    if ({UART_TX, push_ready, tx_busy, LED} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state got tx=%b rdy=%b busy=%b led=%0d want 1 1 0 0", UART_TX, push_ready, tx_busy, LED);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if (tx_busy !== 1'b0 || UART_TX !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_push_ignored cyc=%0d got busy=%b tx=%b want busy=0 tx=1", cyc, tx_busy, UART_TX);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] got;
    do_reset();
    tick(1'b1, 8'hA5, 1'b1);
    vectors++;
    if (UART_TX !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pre got tx=%b want 1", UART_TX);
    end
    tick(1'b0, 8'h00, 1'b1);
    vectors++;
    if (UART_TX !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency got tx=%b want 0", UART_TX);
    end
    for (int i = 0; i < FRAME_CYC + 4; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL single cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
    end
    vectors++;
    if (LED !== 8'd1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end got led=%0d busy=%b want led=1 busy=0", LED, tx_busy);
    end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_rx got n=%0d byte=%h want n=1 byte=a5", rx_q.size(), got);
    end
  endtask

  task automatic test_back_to_back();
    int f0, f1;
    logic prev;
    logic [7:0] g0, g1;
    do_reset();
    f0 = -1; f1 = -1; prev = UART_TX;
    for (int i = 0; i < 2 * FRAME_CYC + 8; i++) begin
      tick(i < 2, (i == 0) ? 8'h00 : 8'hFF, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
      if (prev === 1'b1 && UART_TX === 1'b0) begin
        if (f0 < 0) f0 = cyc; else if (f1 < 0) f1 = cyc;
      end
      prev = UART_TX;
    end
    vectors++;
    if (f0 < 0 || f1 < 0 || (f1 - f0) != FRAME_CYC) begin
      miscompares++;
      $display("FAIL b2b_spacing got %0d cycles want %0d", f1 - f0, FRAME_CYC);
    end
    g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    vectors++;
    if (LED !== 8'd2 || rx_q.size() != 2 || g0 !== 8'h00 || g1 !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_end got led=%0d n=%0d %h %h want led=2 n=2 00 ff", LED, rx_q.size(), g0, g1);
    end
  endtask

  task automatic test_full_wrap();
    int bad;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, (i < 9) ? 8'(i + 1) : 8'hEE, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL full cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
      if (i == 8) begin
        vectors++;
        if (push_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL full_ready got rdy=%b want 0", push_ready);
        end
      end
    end
    for (int i = 0; i < 9 * FRAME_CYC + 10; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL wrap cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
    end
    bad = 0;
    foreach (rx_q[k]) if (rx_q[k] !== 8'(k + 1)) bad++;
    vectors++;
    if (rx_q.size() != 9 || bad != 0 || LED !== 8'd9) begin
      miscompares++;
      $display("FAIL wrap_order got n=%0d wrong=%0d led=%0d want n=9 wrong=0 led=9", rx_q.size(), bad, LED);
    end
  endtask

  task automatic test_reset_mid();
    bit found, saw_low;
    do_reset();
    tick(1'b1, 8'h3C, 1'b1);
    tick(1'b1, 8'h11, 1'b1);
    tick(1'b1, 8'h22, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL midrst_pre cyc=%0d got tx=%b busy=%b want tx=%b busy=%b", cyc, UART_TX, tx_busy, m_tx, m_busy);
      end
      if (m_act && m_cur == 8'h3C && (m_t / CPB) == 4 && (m_t % CPB) == 1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midrst_timeout got no data bit 3 want bit 3 within 200 cycles");
    end
    tick(1'b0, 8'h00, 1'b0);
    vectors++;
    if ({UART_TX, tx_busy, LED} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL midrst_state got tx=%b busy=%b led=%0d want 1 0 0", UART_TX, tx_busy, LED);
    end
    saw_low = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (UART_TX !== 1'b1 || tx_busy !== 1'b0) saw_low = 1'b1;
    end
    vectors++;
    if (saw_low || rx_q.size() != 0 || LED !== 8'd0) begin
      miscompares++;
      $display("FAIL midrst_quiet got activity=%b n=%0d led=%0d want 0 0 0", saw_low, rx_q.size(), LED);
    end
  endtask

  task automatic test_simul();
    logic [7:0] g0, g1;
    do_reset();
    tick(1'b1, 8'h5A, 1'b1);
    tick(1'b1, 8'hC3, 1'b1);
    vectors++;
    if (push_ready !== 1'b1 || tx_busy !== 1'b1 || UART_TX !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_pop got rdy=%b busy=%b tx=%b want 1 1 0", push_ready, tx_busy, UART_TX);
    end
    for (int i = 0; i < 2 * FRAME_CYC + 6; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL simul cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
    end
    g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    vectors++;
    if (LED !== 8'd2 || rx_q.size() != 2 || g0 !== 8'h5A || g1 !== 8'hC3) begin
      miscompares++;
      $display("FAIL simul_end got led=%0d n=%0d %h %h want led=2 n=2 5a c3", LED, rx_q.size(), g0, g1);
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    p = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) p = $urandom_range(0, 100);
      tick($urandom_range(0, 99) < p, 8'($urandom), $urandom_range(0, 399) != 0);
      vectors++;
      if ({UART_TX, push_ready, tx_busy, LED} !== {m_tx, m_ready, m_busy, m_led}) begin
        miscompares++;
        $display("FAIL random cyc=%0d got tx=%b rdy=%b busy=%b led=%0d want tx=%b rdy=%b busy=%b led=%0d",
                 cyc, UART_TX, push_ready, tx_busy, LED, m_tx, m_ready, m_busy, m_led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_reset_mid();
    test_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
